rgb_pwm_fader: RTL and testbench

- Upstream stage for the iCE40 hard RGB LED driver (SB_RGBA_DRV).
- Accepts colour commands over a valid/ready handshake and holds a per-channel current brightness.
- Optionally ramps each channel linearly toward a target colour.
- Produces the three PWM drive bits that connect directly to the driver's RGBxPWM inputs.

---
 rtl/rgb_pwm_fader_if.sv | 26 ++
 rtl/rgb_pwm_fader.sv | 136 +++++++++++++
 tb/tb_rgb_pwm_fader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/rgb_pwm_fader_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rgb_pwm_fader_if : colour command handshake (valid/ready, RGB levels, fade)
// Rev 1.0
// ----------------------------------------------------------------------------
interface rgb_pwm_fader_if #(
  parameter int PWM_BITS = 8
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [PWM_BITS-1:0] cmd_red;
  logic [PWM_BITS-1:0] cmd_green;
  logic [PWM_BITS-1:0] cmd_blue;
  logic                cmd_fade;

  modport master (
    output cmd_valid, cmd_red, cmd_green, cmd_blue, cmd_fade,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_red, cmd_green, cmd_blue, cmd_fade,
    output cmd_ready
  );
endinterface
`default_nettype wire

// File: rtl/rgb_pwm_fader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rgb_pwm_fader : RGB level holder with linear fader and glitch-free PWM
// Rev 1.0
// ----------------------------------------------------------------------------
module rgb_pwm_fader #(
  parameter int PWM_BITS = 8,
  parameter int FADE_DIV = 187500
) (
  input  wire logic      clk,
  input  wire logic      rst,
  rgb_pwm_fader_if.slave cmd,
  output logic           pwm_red,
  output logic           pwm_green,
  output logic           pwm_blue,
  output logic           busy
);
  localparam int                   c_PRESC_W   = $clog2(FADE_DIV);
  localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(FADE_DIV - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    FADING = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [2:0][PWM_BITS-1:0]  w_cmd_lvl;
  logic [2:0][PWM_BITS-1:0]  r_cur;
  logic [2:0][PWM_BITS-1:0]  r_tgt;
  logic [2:0][PWM_BITS-1:0]  r_duty;
  logic [2:0][PWM_BITS-1:0]  w_cur_nxt;
  logic [2:0][PWM_BITS-1:0]  w_tgt_nxt;
  logic [2:0][PWM_BITS-1:0]  w_step;
  logic [PWM_BITS-1:0]       r_cnt;
  logic [c_PRESC_W-1:0]      r_presc;
  logic [c_PRESC_W-1:0]      w_presc_nxt;
  logic [2:0]                r_pwm;
  logic                      r_ready;
  logic                      r_busy;
  logic                      w_accept;
  logic                      w_tick;

  // Channel index 0 = red, 1 = green, 2 = blue
  assign w_cmd_lvl = {cmd.cmd_blue, cmd.cmd_green, cmd.cmd_red};
  assign w_accept  = cmd.cmd_valid & r_ready;
  assign w_tick    = (r_presc == c_PRESC_MAX);

  always_comb begin
    w_step = r_cur;
    for (int i = 0; i < 3; i++) begin
      if (r_cur[i] < r_tgt[i]) begin
        w_step[i] = r_cur[i] + 1'b1;
      end else if (r_cur[i] > r_tgt[i]) begin
        w_step[i] = r_cur[i] - 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_tgt_nxt   = r_tgt;
    w_presc_nxt = r_presc;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_tgt_nxt = w_cmd_lvl;
          if (!cmd.cmd_fade) begin
            w_cur_nxt = w_cmd_lvl;
          end else begin
            w_presc_nxt = '0;
            if (w_cmd_lvl != r_cur) begin
              w_state_nxt = FADING;
            end
          end
        end
      end
      FADING: begin
        if (w_tick) begin
          w_presc_nxt = '0;
          w_cur_nxt   = w_step;
          if (w_step == r_tgt) begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_presc_nxt = r_presc + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ready/busy follow the next state so they flip on the same edge as the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cur   <= '0;
      r_tgt   <= '0;
      r_presc <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_tgt   <= w_tgt_nxt;
      r_presc <= w_presc_nxt;
      r_ready <= (w_state_nxt == IDLE);
      r_busy  <= (w_state_nxt == FADING);
    end
  end

  // Duty is only reloaded at the period wrap, so no runt pulses appear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_duty <= '0;
      r_pwm  <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (r_cnt == {PWM_BITS{1'b1}}) begin
          r_duty[i] <= r_cur[i];
        end
        r_pwm[i] <= (r_cnt < r_duty[i]);
      end
    end
  end

  assign cmd.cmd_ready = r_ready;
  assign busy          = r_busy;
  assign pwm_red       = r_pwm[0];
  assign pwm_green     = r_pwm[1];
  assign pwm_blue      = r_pwm[2];
endmodule
`default_nettype wire

// File: tb/tb_rgb_pwm_fader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rgb_pwm_fader : directed self-checking bench for rgb_pwm_fader
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_rgb_pwm_fader;
  localparam int PWM_BITS = 8;
  localparam int FADE_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwm_red;
  logic pwm_green;
  logic pwm_blue;
  logic busy;
  int   n_checks = 0;
  int   n_fail   = 0;

  rgb_pwm_fader_if #(.PWM_BITS(PWM_BITS)) cmd_if ();

  rgb_pwm_fader #(
    .PWM_BITS (PWM_BITS),
    .FADE_DIV (FADE_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd_if),
    .pwm_red   (pwm_red),
    .pwm_green (pwm_green),
    .pwm_blue  (pwm_blue),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected level k clocks after a fade accept: one step per FADE_DIV clocks, clamped at target
  function automatic int fade_model(input int start, input int tgt, input int k);
    int s;
    s = k / FADE_DIV;
    if (start < tgt) return (start + s > tgt) ? tgt : start + s;
    return (start - s < tgt) ? tgt : start - s;
  endfunction

  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic f);
    int waited;
    waited = 0;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_red   = r;
    cmd_if.cmd_green = g;
    cmd_if.cmd_blue  = b;
    cmd_if.cmd_fade  = f;
    while (cmd_if.cmd_ready !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("send_accepted", (waited < 2000), 1);
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic count_highs(input int n, output int cr, output int cg, output int cb,
                             output int cbusy);
    cr = 0; cg = 0; cb = 0; cbusy = 0;
    repeat (n) begin
      @(negedge clk);
      cr    += int'(pwm_red === 1'b1);
      cg    += int'(pwm_green === 1'b1);
      cb    += int'(pwm_blue === 1'b1);
      cbusy += int'(busy === 1'b1);
    end
  endtask

  task automatic expect_levels(input string tag, input int r, input int g, input int b);
    int cr, cg, cb, cbusy;
    repeat (300) @(negedge clk);
    count_highs(256, cr, cg, cb, cbusy);
    check({tag, "_red_highs"},   cr, r);
    check({tag, "_green_highs"}, cg, g);
    check({tag, "_blue_highs"},  cb, b);
    check({tag, "_busy_highs"},  cbusy, 0);
  endtask

  // Call right after send() returns: k counts edges since the accept edge
  task automatic watch_fade(input string tag, input int n,
                            input int r0, input int g0, input int b0,
                            input int r1, input int g1, input int b1,
                            output int busy_cnt);
    int bad_cur, bad_rdy;
    bad_cur = 0; bad_rdy = 0; busy_cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      busy_cnt += int'(busy === 1'b1);
      if (cmd_if.cmd_ready === busy) bad_rdy++;
      if (int'(dut.r_cur[0]) != fade_model(r0, r1, k)) bad_cur++;
      if (int'(dut.r_cur[1]) != fade_model(g0, g1, k)) bad_cur++;
      if (int'(dut.r_cur[2]) != fade_model(b0, b1, k)) bad_cur++;
    end
    check({tag, "_cur_track"},      bad_cur, 0);
    check({tag, "_ready_vs_busy"},  bad_rdy, 0);
  endtask

  initial begin
    int cr, cg, cb, cbusy, bcnt, k, waited;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_red   = '0;
    cmd_if.cmd_green = '0;
    cmd_if.cmd_blue  = '0;
    cmd_if.cmd_fade  = 1'b0;

    // Reset state and release
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_if.cmd_ready, 0);
    check("rst_busy",  busy, 0);
    check("rst_pwm",   {pwm_red, pwm_green, pwm_blue}, 0);
    rst = 1'b0;
    #1;
    check("ready_before_edge", cmd_if.cmd_ready, 0);
    @(negedge clk);
    check("ready_first_edge", cmd_if.cmd_ready, 1);
    count_highs(300, cr, cg, cb, cbusy);
    check("idle_pwm_highs", cr + cg + cb, 0);
    check("idle_busy_highs", cbusy, 0);

    // Immediate jump
    send(8'h40, 8'h00, 8'hFF, 1'b0);
    expect_levels("jump", 64, 0, 255);

    // Fade up from (0,0,0)... first return to zero with an immediate command
    send(8'd0, 8'd0, 8'd0, 1'b0);
    send(8'd10, 8'd3, 8'd0, 1'b1);
    watch_fade("fade_up", 50, 0, 0, 0, 10, 3, 0, bcnt);
    check("fade_up_busy_clocks", bcnt, 40);
    expect_levels("fade_up", 10, 3, 0);

    // Fade in both directions
    send(8'd200, 8'd200, 8'd200, 1'b0);
    send(8'd195, 8'd200, 8'd205, 1'b1);
    watch_fade("fade_mix", 30, 200, 200, 200, 195, 200, 205, bcnt);
    check("fade_mix_busy_clocks", bcnt, 20);
    expect_levels("fade_mix", 195, 200, 205);

    // Command held during a fade is consumed only once ready returns
    send(8'd193, 8'd200, 8'd205, 1'b1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_red   = 8'd50;
    cmd_if.cmd_green = 8'd60;
    cmd_if.cmd_blue  = 8'd70;
    cmd_if.cmd_fade  = 1'b0;
    k = 0;
    @(negedge clk);
    while (cmd_if.cmd_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("held_ready_clock", k, 8);
    check("held_cur_red_before", dut.r_cur[0], 193);
    check("held_cur_blue_before", dut.r_cur[2], 205);
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    check("held_cur_after", {8'd0, dut.r_cur[2], dut.r_cur[1], dut.r_cur[0]},
          {8'd0, 8'd70, 8'd60, 8'd50});
    check("held_ready_after", cmd_if.cmd_ready, 1);

    // Fade to the current level: accepted, never busy
    send(8'd50, 8'd60, 8'd70, 1'b1);
    count_highs(20, cr, cg, cb, cbusy);
    check("nop_fade_busy", cbusy, 0);
    check("nop_fade_ready", cmd_if.cmd_ready, 1);

    // Asynchronous reset mid-fade while a PWM output is high
    send(8'd255, 8'd255, 8'd255, 1'b1);
    waited = 0;
    @(negedge clk);
    while (!(pwm_red === 1'b1 && busy === 1'b1) && waited < 600) begin
      @(negedge clk);
      waited++;
    end
    check("pre_reset_pwm_high", (waited < 600), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_pwm",   {pwm_red, pwm_green, pwm_blue}, 0);
    check("async_rst_busy",  busy, 0);
    check("async_rst_ready", cmd_if.cmd_ready, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", cmd_if.cmd_ready, 1);
    check("post_rst_cur", {8'd0, dut.r_cur[2], dut.r_cur[1], dut.r_cur[0]}, 0);
    count_highs(300, cr, cg, cb, cbusy);
    check("post_rst_pwm_highs", cr + cg + cb, 0);
    send(8'h80, 8'h01, 8'h00, 1'b0);
    expect_levels("post_rst_jump", 128, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
